dual_port_ram_ctrl: RTL and testbench
=====================================

Name: dual_port_ram_ctrl

Overview:
- Parametrised successor to the team's 16x16 dual-port SRAM block: one write port, one read port, generic width/depth.
- Adds byte-lane write enables, a read-valid flag and a hardware clear sequencer that zeroes the array after reset or on request.
- Sits between the CPU/accelerator datapath and local scratch storage (weight/image buffers).

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- DEPTH, 16, number of words; any value >= 2, need not be a power of 2.
- ADDR_W, $clog2(DEPTH), address width; localparam, not overridable.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous request to re-zero the whole array.
- we  in  1  write enable.
- wbe  in  DATA_W/8  byte-lane write enables; bit i covers wdata[8i+7:8i].
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re  in  1  read enable.
- raddr  in  ADDR_W  read address.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  rdata holds the result of the read accepted the previous cycle.
- busy  out  1  clear sequence in progress; user ports are ignored while high.

Behaviour:
- Reset values: rdata=0, rvalid=0, busy=1, clear pointer=0, state=CLEAR. Memory contents are not reset directly; the CLEAR sweep zeroes them.
- State machine, 2 states:
  - CLEAR: writes 0 to address clr_ptr each cycle, then increments clr_ptr. When clr_ptr==DEPTH-1 is written, go to READY next cycle, so CLEAR lasts exactly DEPTH cycles. busy=1 throughout.
  - READY: busy=0. clr=1 sends the block to CLEAR with clr_ptr=0. A we/re in that same cycle is still serviced.
- Asserting rst mid-sweep restarts the sweep from address 0.
- Asserting clr during CLEAR is ignored; the sweep does not restart.
- Writes (READY only): on a clk edge with we=1, for each i with wbe[i]=1, mem[waddr] lane i <= wdata lane i. Other lanes hold. we=1 with wbe=0 is a no-op.
- Reads (READY only): on a clk edge with re=1, rdata <= mem[raddr] and rvalid <= 1. Latency is 1 cycle.
- With re=0, rdata holds its last value and rvalid <= 0.
- During CLEAR: re and we are ignored, rvalid=0, and rdata holds its value.
- Out-of-range address (addr >= DEPTH, only possible for non-power-of-2 DEPTH):
  - write: dropped;
  - read: rdata <= 0 with rvalid <= 1.
- Read-during-write to the same address in the same cycle: default returns the OLD word (read-first); see Optional Feature.
- Reads and writes to different addresses in the same cycle are fully independent.

Optional Feature:
- Macro: DPRAM_WRITE_BYPASS_EN.
- Defined: same-address read/write returns the NEW data (write-first). Per lane, enabled lanes come from wdata and disabled lanes from the old mem word. This is a combinational bypass mux ahead of the rdata register; latency stays 1 cycle.
- Undefined: read-first as above, with no bypass mux.

Decomposition:
- Package dpram_pkg holds:
  - typedef enum logic {CLEAR, READY} dpram_state_t;
  - function lane_merge(old, new, be) for the byte-lane merge, shared by the write path and the bypass.
- Sub-module dpram_clr_seq holds the state register, clr_ptr counter and busy output. It drives a write-port override: address=clr_ptr, data=0, all lanes enabled.
- The top level contains the array, the write mux (user vs clear sequencer), the read register and the bypass.

Test Plan:
- Reset then wait: busy=1 for exactly 16 cycles, then 0. Read all 16 addresses -> each rdata=0x0000 with rvalid=1 one cycle after re.
- Write 0xBEEF to addr 3 with wbe=2'b11, then wbe=2'b01 with wdata=0x1234 -> read addr 3 returns 0xBE34.
- Same cycle: we=1, waddr=5, wdata=0xAAAA, re=1, raddr=5, old word 0x5555 -> rdata=0x5555 without the macro, 0xAAAA with DPRAM_WRITE_BYPASS_EN. With wbe=2'b10 and the macro -> 0xAA55.
- Fill memory, assert clr=1 for one cycle -> busy for 16 cycles. re pulses during busy give rvalid=0. Afterwards every address reads 0.
- Assert rst at sweep cycle 7 -> sweep restarts, busy lasts 16 cycles from reset release, and addresses 0..15 all read 0.
- DEPTH=12, DATA_W=32: write addr 13 is dropped; read addr 13 gives rdata=0, rvalid=1. Write/read addr 11 round-trips 0xDEADBEEF.

Source files
------------

// File: rtl/dual_port_ram_ctrl_pkg.sv
// Shared types and helpers for the dual-port RAM controller: FSM state
// encoding and the byte-lane merge used by both the write path and the bypass.
package dpram_pkg;

  typedef enum logic {CLEAR, READY} dpram_state_t;

  // Widest word the merge helper accepts; callers cast to and from DATA_W.
  localparam int MAX_DATA_W = 512;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] lane_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dual_port_ram_ctrl_if.sv
// User-side bus of the dual-port RAM controller: one write port, one read
// port and the busy flag of the clear sequencer.
interface dual_port_ram_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                clr;
  logic                we;
  logic [DATA_W/8-1:0] wbe;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic                re;
  logic [ADDR_W-1:0]   raddr;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                busy;

  modport master (
    output clr, we, wbe, waddr, wdata, re, raddr,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  clr, we, wbe, waddr, wdata, re, raddr,
    output rdata, rvalid, busy
  );
endinterface

// File: rtl/dual_port_ram_ctrl_clr_seq.sv
// Clear sequencer: sweeps zeroes through every address after reset or a clr
// request, and overrides the array write port while doing so.
module dpram_clr_seq
  import dpram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  output logic                      busy,
  output logic                      ov_we,
  output logic [$clog2(DEPTH)-1:0]  ov_addr,
  output logic [DATA_W-1:0]         ov_wdata,
  output logic [DATA_W/8-1:0]       ov_wbe
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  dpram_state_t      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      CLEAR: begin
        if (ptr_q == LAST_ADDR) begin
          state_d = READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign ov_we    = busy;
  assign ov_addr  = ptr_q;
  assign ov_wdata = '0;
  assign ov_wbe   = '1;

endmodule

// File: rtl/dual_port_ram_ctrl.sv
// Dual-port RAM controller: byte-lane writes, registered 1-cycle reads and a
// hardware clear sweep. Define DPRAM_WRITE_BYPASS_EN for write-first reads.
module dual_port_ram_ctrl
  import dpram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  dual_port_ram_ctrl_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BE_W   = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              ov_we;
  logic [ADDR_W-1:0] ov_addr;
  logic [DATA_W-1:0] ov_wdata;
  logic [BE_W-1:0]   ov_wbe;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_wbe;
  logic              w_in_range;
  logic              r_in_range;
  logic [DATA_W-1:0] rd_word;

  function automatic logic [DATA_W-1:0] merge_word(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    return DATA_W'(lane_merge(MAX_DATA_W'(old_word), MAX_DATA_W'(new_word), MAX_BE_W'(be)));
  endfunction

  dpram_clr_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.clr),
    .busy     (busy),
    .ov_we    (ov_we),
    .ov_addr  (ov_addr),
    .ov_wdata (ov_wdata),
    .ov_wbe   (ov_wbe)
  );

  // The sweep owns the write port while busy; user writes are dropped.
  always_comb begin
    if (busy) begin
      mem_we    = ov_we;
      mem_waddr = ov_addr;
      mem_wdata = ov_wdata;
      mem_wbe   = ov_wbe;
    end else begin
      mem_we    = bus.we;
      mem_waddr = bus.waddr;
      mem_wdata = bus.wdata;
      mem_wbe   = bus.wbe;
    end
  end

  assign w_in_range = ({1'b0, mem_waddr} < DEPTH_L);
  assign r_in_range = ({1'b0, bus.raddr} < DEPTH_L);

  // NOTE: the array has no reset; the clear sweep zeroes it, which keeps it
  // mappable onto plain SRAM macros.
  always_ff @(posedge clk) begin
    if (mem_we && w_in_range) begin
      mem[mem_waddr] <= merge_word(mem[mem_waddr], mem_wdata, mem_wbe);
    end
  end

  always_comb begin
    rd_word = '0;
    if (r_in_range) begin
      rd_word = mem[bus.raddr];
`ifdef DPRAM_WRITE_BYPASS_EN
      if (bus.we && (bus.waddr == bus.raddr)) begin
        rd_word = merge_word(rd_word, bus.wdata, bus.wbe);
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
    end else if (busy) begin
      bus.rvalid <= 1'b0;
    end else if (bus.re) begin
      bus.rdata  <= rd_word;
      bus.rvalid <= 1'b1;
    end else begin
      bus.rvalid <= 1'b0;
    end
  end

  assign bus.busy = busy;

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Scoreboard bench for dual_port_ram_ctrl: a 16x16 instance and a 12x32
// instance driven with directed and random traffic against an array model.
module tb_dual_port_ram_ctrl;

  typedef struct {
    int          issue;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dual_port_ram_ctrl_if #(.DATA_W(16), .DEPTH(16)) ifa ();
  dual_port_ram_ctrl_if #(.DATA_W(32), .DEPTH(12)) ifb ();

  dual_port_ram_ctrl #(.DATA_W(16), .DEPTH(16)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
  dual_port_ram_ctrl #(.DATA_W(32), .DEPTH(12)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

  // Reference model: plain word arrays indexed by port, plus a countdown of
  // remaining clear-sweep cycles.
  logic [31:0] mdl [2][16];
  int          busy_left [2];
  int          depth [2] = '{16, 12};
  int          nbytes [2] = '{2, 4};
  exp_t        q0 [$];
  exp_t        q1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be, input int nb);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < nb; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] dut_rdata(input int p);
    return (p == 0) ? 32'(ifa.rdata) : ifb.rdata;
  endfunction
  function automatic logic dut_rvalid(input int p);
    return (p == 0) ? ifa.rvalid : ifb.rvalid;
  endfunction
  function automatic logic dut_busy(input int p);
    return (p == 0) ? ifa.busy : ifb.busy;
  endfunction

  task automatic idle_inputs();
    ifa.clr = 0; ifa.we = 0; ifa.wbe = '0; ifa.waddr = '0; ifa.wdata = '0; ifa.re = 0; ifa.raddr = '0;
    ifb.clr = 0; ifb.we = 0; ifb.wbe = '0; ifb.waddr = '0; ifb.wdata = '0; ifb.re = 0; ifb.raddr = '0;
  endtask

  task automatic zero_model(input int p);
    for (int i = 0; i < 16; i++) mdl[p][i] = '0;
  endtask

  task automatic do_reset(input int p);
    if (p == 0) rst_a = 1'b1; else rst_b = 1'b1;
    #2;
    check(p ? "b_reset_rdata" : "a_reset_rdata", dut_rdata(p), 32'h0);
    check(p ? "b_reset_rvalid" : "a_reset_rvalid", 32'(dut_rvalid(p)), 32'h0);
    check(p ? "b_reset_busy" : "a_reset_busy", 32'(dut_busy(p)), 32'h1);
    @(posedge clk); #1;
    if (p == 0) rst_a = 1'b0; else rst_b = 1'b0;
    busy_left[p] = depth[p];
    zero_model(p);
  endtask

  // One clock cycle of user traffic on port p; the model decides what the DUT
  // must do with it and queues the expected read response.
  task automatic cyc_op(input int p, input bit clr, input bit we, input logic [3:0] wbe,
                        input logic [3:0] waddr, input logic [31:0] wdata,
                        input bit re, input logic [3:0] raddr);
    bit   was_busy;
    exp_t e;
    was_busy = (busy_left[p] > 0);
    check(p ? "b_busy" : "a_busy", 32'(dut_busy(p)), 32'(was_busy));
    if (!was_busy) begin
      if (re) begin
        e.issue = cyc;
        e.data  = (int'(raddr) < depth[p]) ? mdl[p][raddr] : 32'h0;
`ifdef DPRAM_WRITE_BYPASS_EN
        if (we && raddr == waddr && int'(raddr) < depth[p]) e.data = merge(e.data, wdata, wbe, nbytes[p]);
`endif
        if (p == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (we && int'(waddr) < depth[p]) mdl[p][waddr] = merge(mdl[p][waddr], wdata, wbe, nbytes[p]);
      if (clr) begin
        busy_left[p] = depth[p];
        zero_model(p);
      end
    end else begin
      busy_left[p]--;
    end
    if (p == 0) begin
      ifa.clr = clr; ifa.we = we; ifa.wbe = wbe[1:0]; ifa.waddr = waddr;
      ifa.wdata = wdata[15:0]; ifa.re = re; ifa.raddr = raddr;
    end else begin
      ifb.clr = clr; ifb.we = we; ifb.wbe = wbe; ifb.waddr = waddr;
      ifb.wdata = wdata; ifb.re = re; ifb.raddr = raddr;
    end
    @(posedge clk); #1;
    idle_inputs();
    if (was_busy) check(p ? "b_rvalid_busy" : "a_rvalid_busy", 32'(dut_rvalid(p)), 32'h0);
  endtask

  task automatic idle(input int p, input int n);
    for (int i = 0; i < n; i++) cyc_op(p, 0, 0, 4'h0, 4'h0, 32'h0, 0, 4'h0);
  endtask

  task automatic wr(input int p, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    cyc_op(p, 0, 1, be, a, d, 0, 4'h0);
  endtask

  task automatic rd(input int p, input logic [3:0] a);
    cyc_op(p, 0, 0, 4'h0, 4'h0, 32'h0, 1, a);
  endtask

  task automatic read_all(input int p);
    for (int i = 0; i < depth[p]; i++) rd(p, 4'(i));
    idle(p, 2);
  endtask

  task automatic pop_check(input int p, input logic [31:0] data);
    exp_t e;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL %s: rvalid with rdata=%h, required no response (cycle %0d)",
               p ? "b_unexpected" : "a_unexpected", data, cyc);
    end else begin
      if (p == 0) e = q0.pop_front(); else e = q1.pop_front();
      check(p ? "b_rdata" : "a_rdata", data, e.data);
      check(p ? "b_latency" : "a_latency", 32'(cyc), 32'(e.issue + 1));
    end
  endtask

  always @(negedge clk) begin
    if (!rst_a && ifa.rvalid) pop_check(0, 32'(ifa.rdata));
    if (!rst_b && ifb.rvalid) pop_check(1, ifb.rdata);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    #1;

    // Port A: reset sweep, then every word reads zero.
    do_reset(0);
    idle(0, 17);
    read_all(0);

    // Byte-lane partial write.
    wr(0, 4'd3, 32'hBEEF, 4'b11);
    wr(0, 4'd3, 32'h1234, 4'b01);
    rd(0, 4'd3);

    // Same-address read during write, full and upper-lane-only.
    wr(0, 4'd5, 32'h5555, 4'b11);
    cyc_op(0, 0, 1, 4'b11, 4'd5, 32'hAAAA, 1, 4'd5);
    wr(0, 4'd5, 32'h5555, 4'b11);
    cyc_op(0, 0, 1, 4'b10, 4'd5, 32'hAAAA, 1, 4'd5);
    rd(0, 4'd5);
    idle(0, 2);

    // Fill, request a clear, probe reads and writes while busy.
    for (int i = 0; i < 16; i++) wr(0, 4'(i), $urandom, 4'b11);
    cyc_op(0, 1, 0, 4'h0, 4'h0, 32'h0, 0, 4'h0);
    for (int i = 0; i < 16; i++) cyc_op(0, (i == 4), 1, 4'b11, 4'(i), 32'hFFFF, 1, 4'(i));
    idle(0, 1);
    read_all(0);

    // Reset in the middle of a sweep restarts it.
    for (int i = 0; i < 16; i++) wr(0, 4'(i), $urandom, 4'b11);
    rd(0, 4'd7);
    idle(0, 2);
    do_reset(0);
    idle(0, 7);
    do_reset(0);
    idle(0, 17);
    read_all(0);

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 400; i++) begin
      cyc_op(0, ($urandom_range(0, 49) == 0), $urandom_range(0, 1), 4'($urandom),
             4'($urandom), $urandom, $urandom_range(0, 1), 4'($urandom));
    end
    idle(0, 20);

    // Port B: non-power-of-2 depth with out-of-range addresses.
    do_reset(1);
    idle(1, 13);
    read_all(1);
    wr(1, 4'd13, 32'hCAFEF00D, 4'hF);
    rd(1, 4'd13);
    wr(1, 4'd11, 32'hDEADBEEF, 4'hF);
    rd(1, 4'd11);
    cyc_op(1, 0, 1, 4'b0101, 4'd11, 32'h11223344, 1, 4'd11);
    rd(1, 4'd11);
    idle(1, 2);
    for (int i = 0; i < 250; i++) begin
      cyc_op(1, ($urandom_range(0, 59) == 0), $urandom_range(0, 1), 4'($urandom),
             4'($urandom), $urandom, $urandom_range(0, 1), 4'($urandom));
    end
    idle(1, 20);

    check("a_pending", 32'(q0.size()), 32'h0);
    check("b_pending", 32'(q1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
